// File: rtl/dmem_block_responder_if.sv
// Block bus between the data cache (master) and the memory responder (slave).
interface dmem_block_responder_if;
    logic [31:0]  blk_addr;
    logic         blk_read_req;
    logic         blk_write_req;
    logic [255:0] blk_write_data;
    logic [255:0] blk_read_data;
    logic         blk_read_valid;
    logic         blk_write_valid;
    logic         busy;

    modport master (
        output blk_addr,
        output blk_read_req,
        output blk_write_req,
        output blk_write_data,
        input  blk_read_data,
        input  blk_read_valid,
        input  blk_write_valid,
        input  busy
    );

    modport slave (
        input  blk_addr,
        input  blk_read_req,
        input  blk_write_req,
        input  blk_write_data,
        output blk_read_data,
        output blk_read_valid,
        output blk_write_valid,
        output busy
    );
endinterface

// File: rtl/dmem_block_responder.sv
// Memory-side responder for 256-bit block fills and writebacks with a fixed
// access latency and a backing array of 2**IDX_BITS blocks.
module dmem_block_responder #(
    parameter int unsigned LATENCY  = 4,
    parameter int unsigned IDX_BITS = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    dmem_block_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_e;

    localparam int unsigned DEPTH    = 1 << IDX_BITS;
    localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic [255:0]          wdata_q, wdata_d;
    logic [255:0]          rdata_q, rdata_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_valid_q, wr_valid_d;
    logic                  mem_we;
    logic                  busy_o;
    logic [IDX_BITS-1:0]   req_idx;
    logic [255:0]          mem_q [DEPTH];

    // Address bits outside the block index alias and are deliberately dropped.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{bus.blk_addr[31:5+IDX_BITS], bus.blk_addr[4:0]};

    assign req_idx = bus.blk_addr[4+IDX_BITS:5];

    // State register plus all resettable datapath flops.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            wr_valid_q <= wr_valid_d;
        end
    end

    // Backing array; never cleared, and a reset on the completion edge suppresses the write.
    always_ff @(posedge CLK) begin
        if (!RESET && mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Next-state: accept in IDLE (write wins), count down, return to IDLE at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.blk_write_req) begin
                    state_d = WR_WAIT;
                    cnt_d   = CNT_INIT;
                    idx_d   = req_idx;
                    wdata_d = bus.blk_write_data;
                end else if (bus.blk_read_req) begin
                    state_d = RD_WAIT;
                    cnt_d   = CNT_INIT;
                    idx_d   = req_idx;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: completion strobes, read data capture, array write enable, busy.
    always_comb begin
        rd_valid_d = 1'b0;
        wr_valid_d = 1'b0;
        rdata_d    = rdata_q;
        mem_we     = 1'b0;
        busy_o     = (state_q != IDLE);
        if (cnt_q == '0) begin
            if (state_q == RD_WAIT) begin
                rd_valid_d = 1'b1;
                rdata_d    = mem_q[idx_q];
            end else if (state_q == WR_WAIT) begin
                wr_valid_d = 1'b1;
                mem_we     = 1'b1;
            end
        end
    end

    assign bus.blk_read_data   = rdata_q;
    assign bus.blk_read_valid  = rd_valid_q;
    assign bus.blk_write_valid = wr_valid_q;
    assign bus.busy            = busy_o;
endmodule

// File: tb/tb_dmem_block_responder.sv
// Directed bench: one responder at LATENCY=4 and one at LATENCY=1.
module tb_dmem_block_responder;
    localparam int unsigned LAT_A = 4;
    localparam int unsigned LAT_B = 1;
    localparam int          TMO   = 50;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dmem_block_responder_if ifa ();
    dmem_block_responder_if ifb ();

    dmem_block_responder #(.LATENCY(LAT_A), .IDX_BITS(8)) u_dut_a (
        .CLK(CLK), .RESET(RESET), .bus(ifa)
    );
    dmem_block_responder #(.LATENCY(LAT_B), .IDX_BITS(8)) u_dut_b (
        .CLK(CLK), .RESET(RESET), .bus(ifb)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wd;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs[10];

    localparam logic [255:0] P_DEAD = {8{32'hDEADBEEF}};
    localparam logic [255:0] P1 = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] P2 = {8{32'hA5A5_0004}};
    localparam logic [255:0] P3 = {8{32'h5A5A_0005}};
    localparam logic [255:0] P4 = {8{32'hFFFF_00FF}};
    localparam logic [255:0] P5 = {8{32'h0000_4040}};
    localparam logic [255:0] P6 = {8{32'hBAD0_BAD0}};
    localparam logic [255:0] P7 = {8{32'h7777_0000}};
    localparam logic [255:0] P8 = {8{32'h8888_0001}};

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic rv(input bit d1);
        return d1 ? ifb.blk_read_valid : ifa.blk_read_valid;
    endfunction
    function automatic logic wv(input bit d1);
        return d1 ? ifb.blk_write_valid : ifa.blk_write_valid;
    endfunction
    function automatic logic bsy(input bit d1);
        return d1 ? ifb.busy : ifa.busy;
    endfunction
    function automatic logic [255:0] rdat(input bit d1);
        return d1 ? ifb.blk_read_data : ifa.blk_read_data;
    endfunction

    task automatic drive(input bit d1, input bit w, input bit r, input logic [31:0] a,
                         input logic [255:0] d);
        if (d1) begin
            ifb.blk_write_req = w; ifb.blk_read_req = r;
            ifb.blk_addr = a; ifb.blk_write_data = d;
        end else begin
            ifa.blk_write_req = w; ifa.blk_read_req = r;
            ifa.blk_addr = a; ifa.blk_write_data = d;
        end
    endtask

    // Counts falling edges until the selected valid is seen; -1 on timeout.
    task automatic wait_valid(input bit d1, input bit wr, output int lat);
        lat = -1;
        for (int c = 1; c <= TMO; c++) begin
            @(negedge CLK);
            if (!d1 && c == 1) chk("busy_inflight", {255'd0, bsy(d1)}, 256'd1);
            if (wr ? wv(d1) : rv(d1)) begin
                lat = c;
                chk("other_valid_low", {255'd0, wr ? rv(d1) : wv(d1)}, 256'd0);
                break;
            end
        end
    endtask

    // Full transaction: request, wait for the pulse, drop request, check pulse width.
    task automatic do_txn(input bit d1, input bit wr, input logic [31:0] a,
                          input logic [255:0] d, output logic [255:0] rd, output int lat);
        @(negedge CLK);
        drive(d1, wr, !wr, a, d);
        wait_valid(d1, wr, lat);
        rd = rdat(d1);
        drive(d1, 1'b0, 1'b0, a, d);
        @(negedge CLK);
        chk("pulse_width", {255'd0, wr ? wv(d1) : rv(d1)}, 256'd0);
    endtask

    initial begin
        logic [255:0] rd;
        int           lat;
        bit           saw;

        vecs[0] = '{1'b1, 32'h0000_0060, P_DEAD, '0};
        vecs[1] = '{1'b0, 32'h0000_0060, '0,     P_DEAD};
        vecs[2] = '{1'b1, 32'h2000_0020, P1,     '0};
        vecs[3] = '{1'b0, 32'h0000_0020, '0,     P1};
        vecs[4] = '{1'b0, 32'h0000_003F, '0,     P1};
        vecs[5] = '{1'b1, 32'h0000_0080, P2,     '0};
        vecs[6] = '{1'b1, 32'h0000_00A0, P3,     '0};
        vecs[7] = '{1'b1, 32'h0000_1FE0, P4,     '0};
        vecs[8] = '{1'b0, 32'hFFFF_FFE0, '0,     P4};
        vecs[9] = '{1'b0, 32'h0000_00A0, '0,     P3};

        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge CLK);
        chk("rst_busy",  {255'd0, ifa.busy}, 256'd0);
        chk("rst_rv",    {255'd0, ifa.blk_read_valid}, 256'd0);
        chk("rst_wv",    {255'd0, ifa.blk_write_valid}, 256'd0);
        chk("rst_rdata", ifa.blk_read_data, 256'd0);
        RESET = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_txn(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wd, rd, lat);
            chk($sformatf("vec%0d_latency", i), 256'(lat), 256'(LAT_A + 1));
            if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        end

        // Simultaneous write and read: write first, held read taken right after.
        @(negedge CLK);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0040, P5);
        wait_valid(1'b0, 1'b1, lat);
        chk("both_wr_latency", 256'(lat), 256'(LAT_A + 1));
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0040, '0);
        wait_valid(1'b0, 1'b0, lat);
        chk("both_rd_latency", 256'(lat), 256'(LAT_A + 1));
        chk("both_rd_data", ifa.blk_read_data, P5);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);

        // Request dropped and address changed after accept: original read completes.
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0080, '0);
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0, 32'h0000_00A0, '0);
        wait_valid(1'b0, 1'b0, lat);
        chk("drop_latency", 256'(lat), 256'(LAT_A));
        chk("drop_rdata", ifa.blk_read_data, P2);
        @(negedge CLK);

        // Reset two cycles into a write to idx 5 aborts it.
        drive(1'b0, 1'b1, 1'b0, 32'h0000_00A0, P6);
        saw = 1'b0;
        @(negedge CLK);
        saw |= ifa.blk_write_valid;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        saw |= ifa.blk_write_valid;
        RESET = 1'b1;
        @(negedge CLK);
        chk("abort_busy", {255'd0, ifa.busy}, 256'd0);
        chk("abort_rdata_cleared", ifa.blk_read_data, 256'd0);
        RESET = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            saw |= ifa.blk_write_valid;
        end
        chk("abort_no_wvalid", {255'd0, saw}, 256'd0);
        do_txn(1'b0, 1'b0, 32'h0000_00A0, '0, rd, lat);
        chk("abort_old_data", rd, P3);

        // LATENCY=1 responder: preload two blocks, then back-to-back held reads.
        do_txn(1'b1, 1'b1, 32'h0000_0000, P7, rd, lat);
        chk("l1_wr0_latency", 256'(lat), 256'(LAT_B + 1));
        do_txn(1'b1, 1'b1, 32'h0000_0020, P8, rd, lat);
        chk("l1_wr1_latency", 256'(lat), 256'(LAT_B + 1));
        @(negedge CLK);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0000, '0);
        wait_valid(1'b1, 1'b0, lat);
        chk("l1_rd0_latency", 256'(lat), 256'(LAT_B + 1));
        chk("l1_rd0_data", ifb.blk_read_data, P7);
        chk("l1_rd0_idle", {255'd0, ifb.busy}, 256'd0);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0020, '0);
        wait_valid(1'b1, 1'b0, lat);
        chk("l1_rd1_gap_latency", 256'(lat), 256'(LAT_B + 1));
        chk("l1_rd1_data", ifb.blk_read_data, P8);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        chk("l1_end_rv", {255'd0, ifb.blk_read_valid}, 256'd0);
        chk("l1_end_busy", {255'd0, ifb.busy}, 256'd0);
        chk("l1_hold_rdata", ifb.blk_read_data, P8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
